// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin arbiter that feeds the 8-to-3 one-hot encoder.
package rr_arb_pkg;
  localparam int N_DEFAULT = 8;

  typedef enum logic {IDLE, GRANT} rr_state_t;

  // Sized for the largest legal requester count (16); callers truncate to their index width.
  function automatic logic [3:0] onehot_to_idx(input logic [15:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < 16; i++)
      if (oh[i]) idx |= 4'(i);
    return idx;
  endfunction
endpackage

// File: rtl/rr_arbiter8_if.sv
// Request/grant handshake bundle between requesters, arbiter and encoder.
// Carries the lock input only when RR_ARB_LOCK_EN is defined.
interface rr_arbiter8_if
  import rr_arb_pkg::*;
#(parameter int N = N_DEFAULT);
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic         gnt_valid;
  logic         gnt_ready;
`ifdef RR_ARB_LOCK_EN
  logic         lock;
`endif

  modport master (
`ifdef RR_ARB_LOCK_EN
    output lock,
`endif
    output req, gnt_ready,
    input  gnt, gnt_valid
  );

  modport slave (
`ifdef RR_ARB_LOCK_EN
    input  lock,
`endif
    input  req, gnt_ready,
    output gnt, gnt_valid
  );
endinterface

// File: rtl/rr_pick.sv
// Combinational cyclic priority picker: lowest set req bit at or above start, wrapping.
module rr_pick #(
  parameter int N    = 8,
  parameter int IDXW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] start,
  output logic [N-1:0]    pick,
  output logic            any
);
  localparam logic [2*N-1:0] ONE = 1;

  logic [N-1:0]   mask;
  logic [2*N-1:0] dbl, iso;

  // Low half holds requests at/above start, high half the full set for the wrapped search;
  // isolating the lowest set bit of the pair yields the cyclic winner.
  always_comb begin
    mask = ~((N'(1) << start) - N'(1));
    dbl  = {req, req & mask};
    iso  = dbl & (~dbl + ONE);
    pick = iso[N-1:0] | iso[2*N-1:N];
    any  = |req;
  end
endmodule

// File: rtl/rr_arbiter8.sv
// Registered round-robin arbiter with valid/ready grant; output is always zero or one-hot.
// Optional RR_ARB_LOCK_EN adds a lock input that re-grants the current owner for bursts.
module rr_arbiter8
  import rr_arb_pkg::*;
#(
  parameter int N = N_DEFAULT,
  localparam int IDXW = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  rr_arbiter8_if.slave      bus
);
  rr_state_t       state_q, state_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic            vld_q;
  logic [IDXW-1:0] ptr_q, ptr_d, gidx, start;
  logic [N-1:0]    pick;
  logic            any, hs, relock;

  assign gidx  = IDXW'(onehot_to_idx(16'(gnt_q)));
  assign hs    = (state_q == GRANT) && bus.gnt_ready;
  assign start = (state_q == IDLE) ? ptr_q : gidx + IDXW'(1);

`ifdef RR_ARB_LOCK_EN
  assign relock = hs && bus.lock && |(bus.req & gnt_q);
`else
  assign relock = 1'b0;
`endif

  rr_pick #(.N(N), .IDXW(IDXW)) u_pick (
    .req   (bus.req),
    .start (start),
    .pick  (pick),
    .any   (any)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: if (any) begin
        gnt_d   = pick;
        state_d = GRANT;
      end
      GRANT: if (hs && !relock) begin
        ptr_d = gidx + IDXW'(1);
        if (any) gnt_d = pick;
        else begin
          gnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      vld_q   <= 1'b0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      vld_q   <= (state_d == GRANT);
      ptr_q   <= ptr_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_valid = vld_q;

  a_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_q));
  a_valid  : assert property (@(posedge clk) disable iff (!rst_n) vld_q == (gnt_q != '0));
  a_stable : assert property (@(posedge clk) disable iff (!rst_n)
                              vld_q && !bus.gnt_ready |=> $stable(gnt_q));
endmodule

// File: tb/tb_rr_arbiter8.sv
// Scoreboard bench for rr_arbiter8: driver queues expected accepted grants, monitor checks handshakes.
module tb_rr_arbiter8;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  rr_arbiter8_if #(.N(8)) bus();
  rr_arbiter8 #(.N(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req_v);
    end
  endtask

  // Monitor: every accepted grant is popped against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (bus.gnt_valid !== (bus.gnt != 8'h00)) begin
        errors++;
        $display("FAIL valid_vs_gnt: valid=%b gnt=%h", bus.gnt_valid, bus.gnt);
      end
      if (bus.gnt_valid && bus.gnt_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_grant: got %h expected none", bus.gnt);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (bus.gnt !== e) begin
            errors++;
            $display("FAIL grant: got %h expected %h", bus.gnt, e);
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    bus.req = 8'hFF;
    bus.gnt_ready = 1'b1;
`ifdef RR_ARB_LOCK_EN
    bus.lock = 1'b0;
`endif
    // Reset held with all requests active
    repeat (3) tick();
    chk("reset_gnt", {1'b0, bus.gnt}, 9'h000);
    chk("reset_valid", {8'h00, bus.gnt_valid}, 9'h000);
    bus.req = 8'h00;
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_after_reset", {bus.gnt_valid, bus.gnt}, 9'h000);

    // Single request, then drop it
    bus.req = 8'h10;
    exp_q.push_back(8'h10);
    tick();
    bus.req = 8'h00;
    tick();
    chk("single_idle", {bus.gnt_valid, bus.gnt}, 9'h000);

    // Full rotation: ptr is now 5
    bus.req = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      logic [7:0] one;
      one = 8'h01;
      exp_q.push_back(one << ((5 + i) % 8));
      tick();
    end
    bus.req = 8'h00;
    tick();
    chk("rotation_idle", {bus.gnt_valid, bus.gnt}, 9'h000);

    // Wrap: grant idx 7 then req 41 searches from 0; ptr ends at 0
    bus.req = 8'h80; exp_q.push_back(8'h80); tick();
    bus.req = 8'h41; exp_q.push_back(8'h01); tick();
    exp_q.push_back(8'h40); tick();
    bus.req = 8'h80; exp_q.push_back(8'h80); tick();
    bus.req = 8'h00; tick();
    chk("wrap_idle", {bus.gnt_valid, bus.gnt}, 9'h000);

    // Stall with req[0] dropped mid-stall
    bus.gnt_ready = 1'b0;
    bus.req = 8'h81;
    tick();
    for (int i = 0; i < 5; i++) begin
      if (i == 2) bus.req = 8'h80;
      tick();
      chk("stall_hold", {bus.gnt_valid, bus.gnt}, 9'h101);
    end
    bus.gnt_ready = 1'b1;
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h80);
    tick();
    bus.req = 8'h00;
    tick();
    chk("stall_idle", {bus.gnt_valid, bus.gnt}, 9'h000);

    // Async reset mid-grant
    bus.gnt_ready = 1'b0;
    bus.req = 8'hFF;
    tick();
    chk("pre_reset_grant", {bus.gnt_valid, bus.gnt}, 9'h101);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_drop", {bus.gnt_valid, bus.gnt}, 9'h000);
    bus.req = 8'h00;
    bus.gnt_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();

`ifdef RR_ARB_LOCK_EN
    bus.req = 8'h06;
    bus.lock = 1'b1;
    exp_q.push_back(8'h02); tick();
    exp_q.push_back(8'h02); tick();
    exp_q.push_back(8'h02); tick();
    bus.lock = 1'b0;
    exp_q.push_back(8'h04); tick();
    bus.req = 8'h00;
    tick();
    chk("lock_idle", {bus.gnt_valid, bus.gnt}, 9'h000);
`endif

    repeat (2) tick();
    chk("scoreboard_drained", 9'(exp_q.size()), 9'h000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
